// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA controller: FSM state encoding, address-mode
// constants and the widths agreed with the slave register block.
package dmac_pkg;

    localparam int DMAC_DATA_WIDTH = 32;
    localparam int DMAC_ADDR_WIDTH = 32;
    localparam int DMAC_SIZE_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RD   = 3'd2,
        ST_RLAT = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    typedef logic [1:0] opmode_t;

    localparam opmode_t OPM_INC_INC = 2'b00;
    localparam opmode_t OPM_INC_FIX = 2'b01;
    localparam opmode_t OPM_FIX_INC = 2'b10;
    localparam opmode_t OPM_FIX_FIX = 2'b11;

    function automatic logic src_fixed(input opmode_t mode);
        return (mode == OPM_FIX_INC) || (mode == OPM_FIX_FIX);
    endfunction

    function automatic logic dst_fixed(input opmode_t mode);
        return (mode == OPM_INC_FIX) || (mode == OPM_FIX_FIX);
    endfunction

endpackage

// File: rtl/dmac_addr_gen.sv
// Word-address pointer: loads a start address, then optionally steps by one,
// wrapping silently at the top of the address space.
module dmac_addr_gen #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmac_master.sv
// DMA transfer engine: requests the bus, then copies data_size words one at a
// time (read, read-latency, write) and raises a sticky opdone when finished.
module dmac_master
    import dmac_pkg::*;
#(
    parameter int DATA_WIDTH = DMAC_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMAC_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       op_start,
    input  logic                       opdone_clear,
    input  logic [ADDR_WIDTH-1:0]      src_addr,
    input  logic [ADDR_WIDTH-1:0]      dest_addr,
    input  logic [DMAC_SIZE_WIDTH-1:0] data_size,
    input  logic [1:0]                 opmode,
    input  logic                       m_grant,
    input  logic [DATA_WIDTH-1:0]      m_din,
    output logic                       m_req,
    output logic                       m_wr,
    output logic [ADDR_WIDTH-1:0]      m_addr,
    output logic [DATA_WIDTH-1:0]      m_dout,
    output logic                       opdone,
    output logic                       busy
);

    state_t                     state;
    opmode_t                    opmode_q;
    logic [DMAC_SIZE_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0]      buffer;
    logic [ADDR_WIDTH-1:0]      src_ptr;
    logic [ADDR_WIDTH-1:0]      dst_ptr;
    logic                       start_load;

    // Pointers follow the FSM: loaded on accepted start, stepped on leaving RD/WR.
    assign start_load = (state == ST_IDLE) && op_start;

    dmac_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_src_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (start_load),
        .load_val (src_addr),
        .inc      ((state == ST_RD) && !src_fixed(opmode_q)),
        .ptr      (src_ptr)
    );

    dmac_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_dst_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (start_load),
        .load_val (dest_addr),
        .inc      ((state == ST_WR) && !dst_fixed(opmode_q)),
        .ptr      (dst_ptr)
    );

    assign m_dout = buffer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            opmode_q <= OPM_INC_INC;
            count    <= '0;
            buffer   <= '0;
            m_req    <= 1'b0;
            m_wr     <= 1'b0;
            m_addr   <= '0;
            opdone   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_start) begin
                        opmode_q <= opmode;
                        count    <= data_size;
                        if (data_size == '0) begin
                            state  <= ST_DONE;
                            opdone <= 1'b1;
                        end else begin
                            state <= ST_REQ;
                            m_req <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (m_grant) begin
                        state  <= ST_RD;
                        m_addr <= src_ptr;
                        m_wr   <= 1'b0;
                    end
                end
                ST_RD: begin
                    state  <= ST_RLAT;
                    m_addr <= '0;
                end
                ST_RLAT: begin
                    state  <= ST_WR;
                    buffer <= m_din;
                    m_addr <= dst_ptr;
                    m_wr   <= 1'b1;
                end
                ST_WR: begin
                    count <= count - DMAC_SIZE_WIDTH'(1);
                    m_wr  <= 1'b0;
                    if (count == DMAC_SIZE_WIDTH'(1)) begin
                        state  <= ST_DONE;
                        m_req  <= 1'b0;
                        busy   <= 1'b0;
                        opdone <= 1'b1;
                        m_addr <= '0;
                    end else begin
                        state  <= ST_RD;
                        m_addr <= src_ptr;
                    end
                end
                ST_DONE: begin
                    // Clear wins over a simultaneous op_start, which is dropped.
                    if (opdone_clear) begin
                        state  <= ST_IDLE;
                        opdone <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmac_master.sv
// Directed bench for dmac_master: drives the slave-side controls and plays the
// arbiter and memory by hand, checking the bus cycle by cycle.
module tb_dmac_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_start;
    logic        opdone_clear;
    logic [31:0] src_addr;
    logic [31:0] dest_addr;
    logic [31:0] data_size;
    logic [1:0]  opmode;
    logic        m_grant;
    logic [31:0] m_din;
    logic        m_req;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_dout;
    logic        opdone;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    dmac_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .opdone_clear (opdone_clear),
        .src_addr     (src_addr),
        .dest_addr    (dest_addr),
        .data_size    (data_size),
        .opmode       (opmode),
        .m_grant      (m_grant),
        .m_din        (m_din),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_addr       (m_addr),
        .m_dout       (m_dout),
        .opdone       (opdone),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered just after the edge into RD; leaves just after the edge out of WR.
    task automatic do_word(input string tag, input logic [31:0] src_exp,
                           input logic [31:0] dst_exp, input logic [31:0] data,
                           input bit last);
        check({tag, " rd addr"}, m_addr, src_exp);
        check({tag, " rd m_wr"}, {31'd0, m_wr}, 32'd0);
        check({tag, " rd m_req"}, {31'd0, m_req}, 32'd1);
        check({tag, " rd busy"}, {31'd0, busy}, 32'd1);
        tick();
        m_din = data;
        check({tag, " rlat addr"}, m_addr, 32'd0);
        check({tag, " rlat m_wr"}, {31'd0, m_wr}, 32'd0);
        tick();
        m_din = ~data;
        check({tag, " wr addr"}, m_addr, dst_exp);
        check({tag, " wr m_wr"}, {31'd0, m_wr}, 32'd1);
        check({tag, " wr data"}, m_dout, data);
        check({tag, " wr opdone"}, {31'd0, opdone}, 32'd0);
        tick();
        if (last) begin
            check({tag, " done opdone"}, {31'd0, opdone}, 32'd1);
            check({tag, " done m_req"}, {31'd0, m_req}, 32'd0);
            check({tag, " done m_wr"}, {31'd0, m_wr}, 32'd0);
            check({tag, " done busy"}, {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic start_op(input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] n, input logic [1:0] m);
        src_addr  = s;
        dest_addr = d;
        data_size = n;
        opmode    = m;
        op_start  = 1'b1;
        tick();
        op_start  = 1'b0;
    endtask

    task automatic clear_done(input string tag);
        opdone_clear = 1'b1;
        tick();
        opdone_clear = 1'b0;
        check({tag, " cleared opdone"}, {31'd0, opdone}, 32'd0);
        check({tag, " cleared busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        op_start     = 1'b0;
        opdone_clear = 1'b0;
        src_addr     = '0;
        dest_addr    = '0;
        data_size    = '0;
        opmode       = 2'b00;
        m_grant      = 1'b0;
        m_din        = '0;
        #12;
        check("reset m_req", {31'd0, m_req}, 32'd0);
        check("reset m_wr", {31'd0, m_wr}, 32'd0);
        check("reset opdone", {31'd0, opdone}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset m_addr", m_addr, 32'd0);
        check("reset m_dout", m_dout, 32'd0);
        reset = 1'b0;
        tick();

        // 1: incrementing copy, grant after two cycles in REQ, opdone on edge 12.
        start_op(32'h10, 32'h20, 32'd3, 2'b00);
        check("t1 req m_req", {31'd0, m_req}, 32'd1);
        check("t1 req busy", {31'd0, busy}, 32'd1);
        tick();
        check("t1 req wait", {31'd0, m_req}, 32'd1);
        m_grant = 1'b1;
        tick();
        do_word("t1w0", 32'h10, 32'h20, 32'hCAFE_0001, 1'b0);
        do_word("t1w1", 32'h11, 32'h21, 32'hCAFE_0002, 1'b0);
        do_word("t1w2", 32'h12, 32'h22, 32'hCAFE_0003, 1'b1);
        m_grant = 1'b0;
        tick();
        check("t1 opdone sticky", {31'd0, opdone}, 32'd1);
        clear_done("t1");

        // 2: both addresses fixed; last write carries the second read's data.
        m_grant = 1'b1;
        start_op(32'h5, 32'h9, 32'd2, 2'b11);
        tick();
        do_word("t2w0", 32'h5, 32'h9, 32'h1111_0001, 1'b0);
        do_word("t2w1", 32'h5, 32'h9, 32'h2222_0002, 1'b1);
        clear_done("t2");

        // 3: zero-length transfer completes without touching the bus.
        start_op(32'h77, 32'h88, 32'd0, 2'b00);
        check("t3 opdone", {31'd0, opdone}, 32'd1);
        check("t3 m_req", {31'd0, m_req}, 32'd0);
        check("t3 busy", {31'd0, busy}, 32'd0);
        clear_done("t3");

        // 4: source wraps from the top of the address space; destination fixed.
        start_op(32'hFFFF_FFFF, 32'h40, 32'd2, 2'b01);
        tick();
        do_word("t4w0", 32'hFFFF_FFFF, 32'h40, 32'hA5A5_0001, 1'b0);
        do_word("t4w1", 32'h0000_0000, 32'h40, 32'hA5A5_0002, 1'b1);
        clear_done("t4");

        // 5: reset asserted during the second write abandons the transfer.
        start_op(32'h100, 32'h200, 32'd4, 2'b00);
        tick();
        do_word("t5w0", 32'h100, 32'h200, 32'h5555_0001, 1'b0);
        check("t5w1 rd addr", m_addr, 32'h101);
        tick();
        m_din = 32'h5555_0002;
        tick();
        check("t5w1 wr m_wr", {31'd0, m_wr}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5 abort m_req", {31'd0, m_req}, 32'd0);
        check("t5 abort m_wr", {31'd0, m_wr}, 32'd0);
        check("t5 abort busy", {31'd0, busy}, 32'd0);
        check("t5 abort opdone", {31'd0, opdone}, 32'd0);
        reset = 1'b0;
        tick();
        start_op(32'h300, 32'h400, 32'd1, 2'b00);
        tick();
        do_word("t5 fresh", 32'h300, 32'h400, 32'h6666_0001, 1'b1);
        clear_done("t5");

        // 6: op_start while busy and op_start alongside clear in DONE are ignored.
        start_op(32'h50, 32'h60, 32'd2, 2'b00);
        src_addr  = 32'hAAA;
        dest_addr = 32'hBBB;
        data_size = 32'd0;
        opmode    = 2'b11;
        op_start  = 1'b1;
        tick();
        op_start  = 1'b0;
        do_word("t6w0", 32'h50, 32'h60, 32'h7777_0001, 1'b0);
        do_word("t6w1", 32'h51, 32'h61, 32'h7777_0002, 1'b1);
        data_size = 32'd3;
        op_start  = 1'b1;
        tick();
        op_start  = 1'b0;
        check("t6 done ignores start", {31'd0, opdone}, 32'd1);
        check("t6 done no req", {31'd0, m_req}, 32'd0);
        op_start     = 1'b1;
        opdone_clear = 1'b1;
        tick();
        op_start     = 1'b0;
        opdone_clear = 1'b0;
        check("t6 clear wins opdone", {31'd0, opdone}, 32'd0);
        tick();
        check("t6 no second xfer req", {31'd0, m_req}, 32'd0);
        check("t6 no second xfer busy", {31'd0, busy}, 32'd0);
        tick();
        check("t6 idle stays quiet", {31'd0, m_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
